// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lends the single UART transmit path to one requester
// per text line, with a 1-entry registered output stage toward the serializer.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ        = 4,
   parameter logic [7:0]  EOL_CHAR     = 8'h0A,
   parameter int unsigned IDLE_TIMEOUT = 1024,
   parameter int unsigned CNT_W        = (IDLE_TIMEOUT == 0) ? 1 : $clog2(IDLE_TIMEOUT + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid_i,
   input  logic [N_REQ*8-1:0]   req_data_i,
   output logic [N_REQ-1:0]     req_ready_o,
   output logic                 tx_valid_o,
   output logic [7:0]           tx_data_o,
   input  logic                 tx_ready_i,
   output logic [N_REQ-1:0]     grant_o,
   output logic                 locked_o,
   output logic                 timeout_o
);

   localparam int unsigned IDX_W      = $clog2(N_REQ);
   localparam bit          TIMEOUT_EN = (IDLE_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic               tx_valid_d;
   logic [7:0]         tx_data_d;
   logic [N_REQ-1:0]   grant_d;
   logic               timeout_d;
   logic               rel;

   logic               found;
   logic [IDX_W-1:0]   winner;
   logic [IDX_W:0]     scan_idx;
   logic               owner_valid;
   logic [7:0]         owner_byte;
   logic               out_free;
   logic               accept;

   // Round-robin scan starting at rr_ptr; first valid requester wins.
   always_comb begin
      found    = 1'b0;
      winner   = rr_ptr_q;
      scan_idx = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         scan_idx = (IDX_W+1)'(rr_ptr_q) + (IDX_W+1)'(k);
         if (scan_idx >= (IDX_W+1)'(N_REQ)) begin
            scan_idx = scan_idx - (IDX_W+1)'(N_REQ);
         end
         if (!found && req_valid_i[scan_idx[IDX_W-1:0]]) begin
            found  = 1'b1;
            winner = scan_idx[IDX_W-1:0];
         end
      end
   end

   assign owner_valid = req_valid_i[owner_q];
   assign owner_byte  = req_data_i[{owner_q, 3'b000} +: 8];
   assign out_free    = !tx_valid_o || tx_ready_i;
   assign accept      = (state_q == S_LOCKED) && owner_valid && out_free;

   always_comb begin
      req_ready_o = '0;
      if (state_q == S_LOCKED) begin
         req_ready_o[owner_q] = out_free;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      idle_cnt_d = idle_cnt_q;
      grant_d    = grant_o;
      timeout_d  = 1'b0;
      tx_valid_d = tx_valid_o;
      tx_data_d  = tx_data_o;
      rel        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d    = S_LOCKED;
               owner_d    = winner;
               grant_d    = N_REQ'(1) << winner;
               idle_cnt_d = '0;
            end
         end
         S_LOCKED: begin
            // A stalled-but-valid owner is not idle; only a dropped valid counts.
            if (owner_valid) begin
               idle_cnt_d = '0;
            end else if (TIMEOUT_EN && idle_cnt_q == CNT_LAST) begin
               rel       = 1'b1;
               timeout_d = 1'b1;
            end else if (idle_cnt_q != {CNT_W{1'b1}}) begin
               idle_cnt_d = idle_cnt_q + CNT_W'(1);
            end
            if (accept && owner_byte == EOL_CHAR) begin
               rel = 1'b1;
            end
            if (rel) begin
               state_d  = S_IDLE;
               grant_d  = '0;
               rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Output register drains independently of ownership.
      if (accept) begin
         tx_valid_d = 1'b1;
         tx_data_d  = owner_byte;
      end else if (tx_ready_i) begin
         tx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         idle_cnt_q <= '0;
         tx_valid_o <= 1'b0;
         tx_data_o  <= '0;
         grant_o    <= '0;
         locked_o   <= 1'b0;
         timeout_o  <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         idle_cnt_q <= idle_cnt_d;
         tx_valid_o <= tx_valid_d;
         tx_data_o  <= tx_data_d;
         grant_o    <= grant_d;
         locked_o   <= (state_d == S_LOCKED);
         timeout_o  <= timeout_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: line-level behavioural model compared
// every cycle, directed scenarios with hand-computed expectations, random traffic.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int TO  = 8;
   localparam int EOL = 8'h0A;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid_i = '0;
   logic [N*8-1:0] req_data_i = '0;
   logic [N-1:0]   req_ready_o;
   logic           tx_valid_o;
   logic [7:0]     tx_data_o;
   logic           tx_ready_i = 1'b0;
   logic [N-1:0]   grant_o;
   logic           locked_o;
   logic           timeout_o;

   uart_tx_arbiter #(.N_REQ(N), .EOL_CHAR(8'h0A), .IDLE_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
      .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
      .grant_o(grant_o), .locked_o(locked_o), .timeout_o(timeout_o)
   );

   initial forever #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int ready_mode = 1;  // 0: stall, 1: always ready, 2: toggle, 3: random
   int src_q[N][$];     // per-requester byte stream; -1 is a one-cycle valid gap
   bit [N-1:0] acc;

   // Event logs
   int gnt_log[$], gnt_cyc[$], fall_cyc[$], out_log[$], out_cyc[$];
   int tout_cnt = 0, tout_cyc = 0;

   // Behavioural model: owner (-1 = unlocked), pointer, idle count, held byte
   int m_own = -1, m_ptr = 0, m_idle = 0, m_data = 0, rst_epoch = 0;
   bit m_hv = 0, m_tout = 0;
   int exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic chk_seq(input string name, input int q[$], input int e[$]);
      chk({name, "_len"}, q.size(), e.size());
      for (int i = 0; i < e.size(); i++) chk(name, qget(q, i), e[i]);
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_own = -1; m_ptr = 0; m_idle = 0; m_hv = 0; m_data = 0; m_tout = 0;
         exp_q.delete();
         rst_epoch++;
      end else begin
         int own_n;
         int b;
         bit a;
         bit rel;
         own_n = m_own; b = 0; a = 0; rel = 0; m_tout = 0;
         if (m_own < 0) begin
            for (int k = 0; k < N; k++) begin
               if (req_valid_i[(m_ptr + k) % N]) begin
                  own_n = (m_ptr + k) % N;
                  break;
               end
            end
            m_idle = 0;
         end else begin
            a = req_valid_i[m_own] && (!m_hv || tx_ready_i);
            if (a) begin
               b = int'(req_data_i[m_own*8 +: 8]);
               exp_q.push_back(b);
               if (b == EOL) rel = 1;
            end
            if (req_valid_i[m_own]) m_idle = 0;
            else if (m_idle + 1 >= TO) begin rel = 1; m_tout = 1; end
            else m_idle++;
            if (rel) begin own_n = -1; m_ptr = (m_own + 1) % N; end
         end
         if (a) begin m_hv = 1; m_data = b; end
         else if (tx_ready_i) m_hv = 0;
         m_own = own_n;
      end
   end

   // Requester and serializer drivers
   initial forever begin
      logic [N-1:0]   vv;
      logic [N*8-1:0] dd;
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < N; i++)
         if (acc[i] && rst_n && src_q[i].size() > 0) void'(src_q[i].pop_front());
      vv = '0;
      dd = req_data_i;
      for (int i = 0; i < N; i++) begin
         if (src_q[i].size() > 0) begin
            if (src_q[i][0] < 0) void'(src_q[i].pop_front());
            else begin vv[i] = 1'b1; dd[i*8 +: 8] = 8'(src_q[i][0]); end
         end
      end
      req_valid_i = vv;
      req_data_i  = dd;
      case (ready_mode)
         0: tx_ready_i = 1'b0;
         1: tx_ready_i = 1'b1;
         2: tx_ready_i = cyc[0];
         default: tx_ready_i = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Compare process
   initial begin
      bit prev_v = 0, prev_r = 0, prev_l = 0;
      int prev_d = 0, prev_g = 0, prev_ep = 0;
      forever begin
         @(negedge clk);
         begin
            int eg;
            int er;
            int e;
            eg = (m_own < 0) ? 0 : (1 << m_own);
            er = (m_own >= 0 && (!m_hv || tx_ready_i)) ? (1 << m_own) : 0;
            chk("tx_valid", int'(tx_valid_o), int'(m_hv));
            chk("tx_data", int'(tx_data_o), m_data);
            chk("grant", int'(grant_o), eg);
            chk("locked", int'(locked_o), int'(m_own >= 0));
            chk("timeout", int'(timeout_o), int'(m_tout));
            chk("req_ready", int'(req_ready_o), er);
            if (prev_ep == rst_epoch && prev_v && !prev_r) begin
               chk("hold_valid", int'(tx_valid_o), 1);
               chk("hold_data", int'(tx_data_o), prev_d);
            end
            if (rst_n && tx_valid_o && tx_ready_i) begin
               e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
               chk("sb_byte", int'(tx_data_o), e);
               out_log.push_back(int'(tx_data_o));
               out_cyc.push_back(cyc);
            end
            if (grant_o != 0 && prev_g == 0) begin
               gnt_log.push_back(int'(grant_o));
               gnt_cyc.push_back(cyc);
            end
            if (prev_l && !locked_o) fall_cyc.push_back(cyc);
            if (timeout_o) begin tout_cnt++; tout_cyc = cyc; end
            acc = req_valid_i & req_ready_o;
            prev_v = tx_valid_o; prev_r = tx_ready_i; prev_d = int'(tx_data_o);
            prev_g = int'(grant_o); prev_l = locked_o; prev_ep = rst_epoch;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic clr_logs();
      gnt_log.delete(); gnt_cyc.delete(); fall_cyc.delete();
      out_log.delete(); out_cyc.delete(); tout_cnt = 0; tout_cyc = 0;
   endtask

   task automatic rst_on();
      step();
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) src_q[i].delete();
      repeat (2) @(posedge clk);
      step();
   endtask

   task automatic rst_off();
      clr_logs();
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      bit done;
      n = 0;
      done = 0;
      while (!done && n < budget) begin
         step();
         n++;
         done = !tx_valid_o && !locked_o;
         for (int i = 0; i < N; i++) if (src_q[i].size() > 0) done = 0;
      end
      chk("drain_in_budget", int'(done), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int e[$];
      int c0;
      int total;
      int cnt[N];
      bit hit;

      // Reset state
      ready_mode = 1;
      rst_on();
      rst_off();
      step();
      chk("rst_tx_valid", int'(tx_valid_o), 0);
      chk("rst_tx_data", int'(tx_data_o), 0);
      chk("rst_grant", int'(grant_o), 0);
      chk("rst_locked", int'(locked_o), 0);
      chk("rst_timeout", int'(timeout_o), 0);
      chk("rst_req_ready", int'(req_ready_o), 0);

      // Single requester "Hi\n"
      clr_logs();
      c0 = cyc;
      src_q[0] = {8'h48, 8'h69, 8'h0A};
      wait_drain(50);
      e = {1}; chk_seq("t1_grant", gnt_log, e);
      chk("t1_grant_lat", qget(gnt_cyc, 0) - c0, 2);
      e = {8'h48, 8'h69, 8'h0A}; chk_seq("t1_bytes", out_log, e);
      chk("t1_b1_next", qget(out_cyc, 1) - qget(out_cyc, 0), 1);
      chk("t1_b2_next", qget(out_cyc, 2) - qget(out_cyc, 1), 1);
      chk("t1_unlock", qget(fall_cyc, 0), qget(out_cyc, 2));
      clr_logs();
      src_q[0] = {8'h0A};
      src_q[1] = {8'h0A};
      wait_drain(50);
      e = {2, 1}; chk_seq("t1_rr_ptr", gnt_log, e);

      // Contention out of reset
      rst_on();
      src_q[0] = {8'h41, 8'h0A};
      src_q[2] = {8'h42, 8'h0A};
      rst_off();
      wait_drain(50);
      e = {1, 4}; chk_seq("t2_grant", gnt_log, e);
      e = {8'h41, 8'h0A, 8'h42, 8'h0A}; chk_seq("t2_bytes", out_log, e);
      chk("t2_idle_gap", qget(gnt_cyc, 1) - qget(fall_cyc, 0), 1);

      // Fairness: 12 one-byte lines
      rst_on();
      for (int i = 0; i < N; i++) src_q[i] = {8'h0A, 8'h0A, 8'h0A};
      rst_off();
      wait_drain(200);
      chk("t3_ngrant", gnt_log.size(), 12);
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int k = 0; k < 12; k++) begin
         chk("t3_order", qget(gnt_log, k), 1 << (k % N));
         for (int i = 0; i < N; i++) if (qget(gnt_log, k) == (1 << i)) cnt[i]++;
      end
      for (int i = 0; i < N; i++) chk("t3_count", cnt[i], 3);

      // Backpressure: toggling tx_ready_i over a 5-byte line
      clr_logs();
      ready_mode = 2;
      src_q[3] = {8'h10, 8'h11, 8'h12, 8'h13, 8'h0A};
      wait_drain(100);
      e = {8'h10, 8'h11, 8'h12, 8'h13, 8'h0A}; chk_seq("t4_bytes", out_log, e);
      chk("t4_no_timeout", tout_cnt, 0);
      ready_mode = 1;

      // Idle timeout
      rst_on();
      src_q[1] = {8'h41};
      src_q[3] = {8'h33, 8'h0A};
      rst_off();
      wait_drain(100);
      chk("t5_tout_cnt", tout_cnt, 1);
      e = {2, 8}; chk_seq("t5_grant", gnt_log, e);
      e = {8'h41, 8'h33, 8'h0A}; chk_seq("t5_bytes", out_log, e);
      chk("t5_tout_delay", tout_cyc - qget(out_cyc, 0), 8);
      chk("t5_regrant", qget(gnt_cyc, 1) - tout_cyc, 1);

      // Reset mid-line with a held byte (rr_ptr advanced to 1 first)
      clr_logs();
      src_q[0] = {8'h0A};
      wait_drain(50);
      ready_mode = 0;
      src_q[2] = {8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h0A};
      hit = 0;
      for (int n = 0; n < 20 && !hit; n++) begin
         step();
         hit = tx_valid_o && (grant_o == 4'b0100);
      end
      chk("t6_reached", int'(hit), 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_tx_valid", int'(tx_valid_o), 0);
      chk("t6_rst_grant", int'(grant_o), 0);
      chk("t6_rst_locked", int'(locked_o), 0);
      for (int i = 0; i < N; i++) src_q[i].delete();
      repeat (2) @(posedge clk);
      step();
      ready_mode = 1;
      src_q[0] = {8'h0A};
      src_q[1] = {8'h0A};
      rst_off();
      wait_drain(50);
      e = {1, 2}; chk_seq("t6_ptr_reset", gnt_log, e);

      // Random traffic against the model
      clr_logs();
      ready_mode = 3;
      total = 0;
      for (int r = 0; r < 60; r++) begin
         int q;
         int len;
         q = $urandom_range(0, N - 1);
         len = $urandom_range(1, 6);
         for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 4) == 0)
               repeat ($urandom_range(1, 12)) src_q[q].push_back(-1);
            src_q[q].push_back($urandom_range(32, 126));
            total++;
         end
         if ($urandom_range(0, 3) != 0) begin
            src_q[q].push_back(EOL);
            total++;
         end
         if (r % 4 == 3) repeat ($urandom_range(0, 20)) step();
      end
      wait_drain(20000);
      chk("t7_byte_count", out_log.size(), total);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
